serial_pattern_gen: RTL and testbench

Serial bit-pattern transmitter: the driving end of the single-bit serial input "x" consumed by the team's sequence-detector FSMs. It loads a parallel word and shifts it out MSB-first, one bit per accepted clock, for a programmable length. It gives the detector a synthesizable stimulus source on-chip and in system-level benches. Like the detectors, it exposes current/next FSM state for waveform debug.

---
 rtl/serial_pattern_gen.sv | 83 ++++++++
 tb/tb_serial_pattern_gen.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_gen.sv
// Serial pattern transmitter: loads a parallel word and shifts it out MSB-first,
// one bit per accepted cycle, for a programmable number of bits.
module serial_pattern_gen #(
    parameter int WIDTH = 64,
    parameter int LEN_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [LEN_W-1:0] len,
    input  logic             ready,
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       cs,
    output logic [1:0]       ns
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10,
        ILL   = 2'b11
    } state_t;

    localparam logic [LEN_W-1:0] WMAX = LEN_W'(WIDTH);

    state_t           cs_q, ns_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_clamped;

    assign len_clamped = (len > WMAX) ? WMAX : len;

    always_comb begin
        ns_d    = cs_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (cs_q)
            IDLE: begin
                if (start && (len != '0)) begin
                    shreg_d = data;
                    cnt_d   = len_clamped;
                    ns_d    = SHIFT;
                end
            end
            SHIFT: begin
                // cnt holds the bits still on or waiting for the line (1..WIDTH)
                if (ready) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1))
                        ns_d = DONE;
                end
            end
            DONE:    ns_d = IDLE;
            default: ns_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cs_q    <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            cs_q    <= ns_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Gate the registered MSB so leftover bits of a short pattern never leak out.
    assign valid = (cs_q == SHIFT);
    assign x     = valid & shreg_q[WIDTH-1];
    assign busy  = (cs_q != IDLE);
    assign done  = (cs_q == DONE);
    assign cs    = cs_q;
    assign ns    = ns_d;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Randomized bench for serial_pattern_gen: a transfer-level model queues the
// expected bits on each accepted start; a monitor compares the DUT every cycle.
module tb_serial_pattern_gen;

    localparam int WIDTH = 64;
    localparam int LEN_W = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] data;
    logic [LEN_W-1:0] len;
    logic             ready;
    logic             x, valid, busy, done;
    logic [1:0]       cs, ns;

    int checks = 0;
    int errors = 0;

    serial_pattern_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .data(data), .len(len),
        .ready(ready), .x(x), .valid(valid), .busy(busy), .done(done),
        .cs(cs), .ns(ns)
    );

    always #5 clk = ~clk;

    // Model: bits still to send, and whether this is the done cycle.
    bit exp_q[$];
    int rem      = 0;
    bit done_cyc = 1'b0;
    int n_done   = 0;

    always @(posedge clk) begin
        if (!rst) begin
            exp_q.delete();
            rem      = 0;
            done_cyc = 1'b0;
        end else if (done_cyc) begin
            done_cyc = 1'b0;
        end else if (rem > 0) begin
            if (ready) begin
                void'(exp_q.pop_front());
                rem--;
                if (rem == 0) done_cyc = 1'b1;
            end
        end else if (start && len != 0) begin
            int n;
            n = (int'(len) > WIDTH) ? WIDTH : int'(len);
            for (int i = 0; i < n; i++) exp_q.push_back(data[WIDTH-1-i]);
            rem = n;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: sample between edges, after inputs and state have settled.
    logic [1:0] ns_prev;
    bit         ns_armed = 1'b0;

    always @(negedge clk) begin
        int exp_cs;
        #1;
        exp_cs = done_cyc ? 2 : (rem > 0 ? 1 : 0);
        chk("cs", int'(cs), exp_cs);
        chk("valid", int'(valid), int'(rem > 0));
        chk("busy", int'(busy), int'(rem > 0 || done_cyc));
        chk("done", int'(done), int'(done_cyc));
        if (rem > 0) chk("x_bit", int'(x), int'(exp_q[0]));
        else         chk("x_idle", int'(x), 0);
        if (done_cyc) begin
            chk("queue_empty_at_done", exp_q.size(), 0);
            n_done++;
        end
        if (ns_armed) chk("ns_predicts_cs", int'(cs), int'(ns_prev));
        ns_prev  = ns;
        ns_armed = (rst === 1'b1);
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input int l);
        data  = d;
        len   = LEN_W'(l);
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        int start_done;
        rst = 1'b0; start = 1'b0; data = '0; len = '0; ready = 1'b1;
        cyc();
        // Reset sweep: random inputs with start asserted must not leave IDLE.
        for (int i = 0; i < 2; i++) begin
            data = {$urandom, $urandom}; len = LEN_W'($urandom); start = 1'b1;
            ready = 1'(($urandom));
            cyc();
        end
        start = 1'b0; rst = 1'b1; ready = 1'b1;
        cyc();

        // Full word.
        start_done = n_done;
        send(64'h3300_0000_0000_0000, 64);
        cyc(68);
        chk("full_word_done_count", n_done - start_done, 1);

        // Short pattern with stalls.
        start_done = n_done;
        data = '0; data[WIDTH-1 -: 8] = 8'hA5;
        len = 8; start = 1'b1; ready = 1'b1;
        cyc(); start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ready = (i % 5 != 1 && i % 5 != 4);
            cyc();
        end
        ready = 1'b1;
        cyc(3);
        chk("a5_done_count", n_done - start_done, 1);

        // Length edge cases.
        send({$urandom, $urandom}, 0);
        cyc(3);
        send({$urandom, $urandom}, 1);
        cyc(4);
        start_done = n_done;
        send({$urandom, $urandom}, 100);
        cyc(68);
        chk("clamp_done_count", n_done - start_done, 1);

        // Start while busy, including in DONE.
        send({$urandom, $urandom}, 12);
        data = {$urandom, $urandom}; len = 20; start = 1'b1;
        cyc(14);
        start = 1'b0;
        cyc(25);

        // Reset mid-operation, then a clean restart.
        start_done = n_done;
        send({$urandom, $urandom}, 64);
        cyc(9);
        rst = 1'b0; cyc(); rst = 1'b1;
        cyc(2);
        chk("no_done_after_abort", n_done - start_done, 0);
        send({$urandom, $urandom}, 64);
        cyc(68);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 99) != 0);
            start = ($urandom_range(0, 3) == 0);
            len   = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 4)) : LEN_W'($urandom);
            data  = {$urandom, $urandom};
            ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        start = 1'b0; ready = 1'b1;
        cyc(70);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
